// File: rtl/seg7_reader_pkg.sv
// seg7_reader_pkg
//   Shared constants for the common-cathode 7-segment reader:
//   segment/nibble/index widths, the blank pattern and the 16-entry
//   hex glyph table (segment order gfedcba, bit0 = a).
package seg7_reader_pkg;

  localparam int SEG_W      = 7;  // segments a..g
  localparam int NIB_W      = 4;  // decoded hex value per digit
  localparam int IDX_W      = 3;  // digit index (up to 8 digits)
  localparam int NUM_GLYPHS = 16;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Entry v sits at [v*SEG_W +: SEG_W]; listed from F down to 0.
  localparam logic [NUM_GLYPHS*SEG_W-1:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
//   Combinational glyph lookup.
//   Ports:
//     pattern : in  7  segment pattern (gfedcba)
//     hit     : out 1  pattern is one of the 16 hex glyphs
//     blank   : out 1  pattern is all segments off
//     value   : out 4  hex value of the glyph (0 when no hit)
module seg7_pattern_decode
  import seg7_reader_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic             hit,
  output logic             blank,
  output logic [NIB_W-1:0] value
);

  logic [NUM_GLYPHS-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GLYPHS; gi++) begin : g_match
      assign match[gi] = (pattern == GLYPH_TABLE[gi*SEG_W +: SEG_W]);
    end
  endgenerate

  // Glyphs are unique, so at most one match bit is set.
  always_comb begin
    value = '0;
    for (int v = 0; v < NUM_GLYPHS; v++) begin
      if (match[v]) value = NIB_W'(v);
    end
  end

  assign hit   = |match;
  assign blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg7_cc_reader.sv
// seg7_cc_reader
//   Reads a multiplexed common-cathode 7-segment display bus and recovers
//   the hex value, decimal point and validity of every digit position.
//   Optional feature macro: SEG7_READER_TIMEOUT_EN (per-digit refresh
//   timeout that clears digit_valid when a digit stops being refreshed).
//   Ports:
//     clk50MHz    : in  1          sole clock, rising edge
//     rst         : in  1          synchronous active-high reset
//     Segments    : in  7          segment anodes, active-high, bit0=a
//     dp          : in  1          decimal-point anode, active-high
//     dig_n       : in  DIGITS     digit cathode selects, active-low
//     bcd_out     : out 4*DIGITS   decoded value, digit i at [4i+3:4i]
//     dp_out      : out DIGITS     captured decimal point per digit
//     digit_valid : out DIGITS     digit holds a recognised hex glyph
//     upd         : out 1          one-cycle commit strobe
//     upd_idx     : out 3          index of the committed digit
//     err         : out 1          one-cycle strobe, unknown pattern
module seg7_cc_reader
  import seg7_reader_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int STABLE_CNT  = 3,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                  clk50MHz,
  input  logic                  rst,
  input  logic [SEG_W-1:0]      Segments,
  input  logic                  dp,
  input  logic [DIGITS-1:0]     dig_n,
  output logic [NIB_W*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  upd,
  output logic [IDX_W-1:0]      upd_idx,
  output logic                  err
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CNT);

  // Two-flop synchronizer; idle state is "no digit selected".
  logic [SEG_W-1:0]  seg_meta_reg, seg_sync_reg;
  logic              dp_meta_reg,  dp_sync_reg;
  logic [DIGITS-1:0] dig_meta_reg, dig_sync_reg;

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      seg_meta_reg <= '0;
      seg_sync_reg <= '0;
      dp_meta_reg  <= 1'b0;
      dp_sync_reg  <= 1'b0;
      dig_meta_reg <= '1;
      dig_sync_reg <= '1;
    end else begin
      seg_meta_reg <= Segments;
      seg_sync_reg <= seg_meta_reg;
      dp_meta_reg  <= dp;
      dp_sync_reg  <= dp_meta_reg;
      dig_meta_reg <= dig_n;
      dig_sync_reg <= dig_meta_reg;
    end
  end

  // Qualification: exactly one cathode active.
  logic [DIGITS-1:0] dig_act;
  logic              one_hot;
  logic [IDX_W-1:0]  idx;

  assign dig_act = ~dig_sync_reg;
  assign one_hot = (dig_act != '0) && ((dig_act & (dig_act - DIGITS'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_act[i]) idx = IDX_W'(i);
    end
  end

  // Run tracking. The whole select vector is compared, which for a
  // qualified sample is the same as comparing the digit index.
  logic [SEG_W-1:0]  seg_prev_reg;
  logic              dp_prev_reg;
  logic [DIGITS-1:0] dig_prev_reg;
  logic [7:0]        run_cnt_reg, run_cnt_next;
  logic              same, commit;

  assign same = (seg_sync_reg == seg_prev_reg) && (dp_sync_reg == dp_prev_reg) &&
                (dig_sync_reg == dig_prev_reg);

  always_comb begin
    run_cnt_next = 8'd0;
    commit       = 1'b0;
    if (one_hot) begin
      if (same && (run_cnt_reg != 8'd0))
        run_cnt_next = (run_cnt_reg == STABLE_MAX) ? STABLE_MAX : run_cnt_reg + 8'd1;
      else
        run_cnt_next = 8'd1;
      // Fire only on the first arrival at STABLE_MAX within a run.
      commit = (run_cnt_next == STABLE_MAX) && !(same && (run_cnt_reg == STABLE_MAX));
    end
  end

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      seg_prev_reg <= '0;
      dp_prev_reg  <= 1'b0;
      dig_prev_reg <= '1;
      run_cnt_reg  <= 8'd0;
    end else begin
      seg_prev_reg <= seg_sync_reg;
      dp_prev_reg  <= dp_sync_reg;
      dig_prev_reg <= dig_sync_reg;
      run_cnt_reg  <= run_cnt_next;
    end
  end

  // Glyph decode of the synchronized pattern.
  logic             dec_hit, dec_blank;
  logic [NIB_W-1:0] dec_value, nib;
  logic             bad;

  seg7_pattern_decode u_decode (
    .pattern (seg_sync_reg),
    .hit     (dec_hit),
    .blank   (dec_blank),
    .value   (dec_value)
  );

  assign nib = dec_hit ? dec_value : (dec_blank ? 4'h0 : 4'hF);
  assign bad = !dec_hit && !dec_blank;

  // Per-digit write enables.
  logic [DIGITS-1:0] wr_en;
  logic [DIGITS-1:0] to_expire;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_wr
      assign wr_en[gi] = commit && (idx == IDX_W'(gi));
    end
  endgenerate

`ifdef SEG7_READER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_reg [DIGITS];

  // Counters saturate at TO_MAX so the expiry pulse fires once.
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) to_cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_en[i])
          to_cnt_reg[i] <= '0;
        else if (to_cnt_reg[i] != TO_MAX)
          to_cnt_reg[i] <= to_cnt_reg[i] + TO_W'(1);
      end
    end
  end

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_to
      assign to_expire[gi] = !wr_en[gi] && (to_cnt_reg[gi] == TO_LAST);
    end
  endgenerate
`else
  // Timeout disabled: never expires (TIMEOUT_CYC is non-negative).
  assign to_expire = {DIGITS{TIMEOUT_CYC < 0}};
`endif

  // Output registers.
  logic [NIB_W*DIGITS-1:0] bcd_reg;
  logic [DIGITS-1:0]       dp_reg, valid_reg;
  logic                    upd_reg, err_reg;
  logic [IDX_W-1:0]        upd_idx_reg;

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      bcd_reg     <= '0;
      dp_reg      <= '0;
      valid_reg   <= '0;
      upd_reg     <= 1'b0;
      err_reg     <= 1'b0;
      upd_idx_reg <= '0;
    end else begin
      upd_reg <= commit;
      err_reg <= commit && bad;
      if (commit) upd_idx_reg <= idx;
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_en[i]) begin
          bcd_reg[i*NIB_W +: NIB_W] <= nib;
          dp_reg[i]                 <= dp_sync_reg;
          valid_reg[i]              <= dec_hit;
        end else if (to_expire[i]) begin
          valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  assign bcd_out     = bcd_reg;
  assign dp_out      = dp_reg;
  assign digit_valid = valid_reg;
  assign upd         = upd_reg;
  assign upd_idx     = upd_idx_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_seg7_cc_reader.sv
// tb_seg7_cc_reader
//   Self-checking bench for seg7_cc_reader (DIGITS=4, STABLE_CNT=3).
//   Expected commits are pushed to a scoreboard when stimulus is driven
//   and popped by a negedge monitor whenever upd is seen.
//   With SEG7_READER_TIMEOUT_EN defined, the timeout sequence also runs.
module tb_seg7_cc_reader;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  Segments;
  logic        dp;
  logic [3:0]  dig_n;
  logic [15:0] bcd_out;
  logic [3:0]  dp_out;
  logic [3:0]  digit_valid;
  logic        upd;
  logic [2:0]  upd_idx;
  logic        err;

  always #5 clk = ~clk;

  seg7_cc_reader #(
    .DIGITS      (DIGITS),
    .STABLE_CNT  (3),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk50MHz    (clk),
    .rst         (rst),
    .Segments    (Segments),
    .dp          (dp),
    .dig_n       (dig_n),
    .bcd_out     (bcd_out),
    .dp_out      (dp_out),
    .digit_valid (digit_valid),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .err         (err)
  );

  typedef struct {
    int          idx;
    logic        err;
    logic [15:0] bcd_all;
    logic [3:0]  dp_all;
    logic [3:0]  valid_all;
  } exp_t;

  typedef struct {
    logic [3:0] dn;
    logic [6:0] seg;
    logic       dpv;
    int         hold;
    bit         commits;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  logic [3:0] vmask = 4'hF;

  // Reference model of the visible digit state.
  logic [15:0] m_bcd = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_valid = '0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] dn, input logic [6:0] s, input logic d);
    dig_n = dn; Segments = s; dp = d;
  endtask

  task automatic idle();
    drive(4'b1111, 7'h00, 1'b0);
  endtask

  task automatic model_reset();
    m_bcd = '0; m_dp = '0; m_valid = '0;
  endtask

  // Push the commit expected for pattern s on digit i.
  task automatic expect_commit(input int i, input logic [6:0] s, input logic d);
    exp_t e;
    logic [3:0] v;
    logic       ok, bad;
    v = 4'hF; ok = 1'b0; bad = 1'b1;
    for (int g = 0; g < 16; g++) begin
      if (glyph_tab[g] == s) begin v = 4'(g); ok = 1'b1; bad = 1'b0; end
    end
    if (s == 7'h00) begin v = 4'h0; bad = 1'b0; end
    m_bcd[i*4 +: 4] = v;
    m_dp[i]         = d;
    m_valid[i]      = ok;
    e.idx = i; e.err = bad;
    e.bcd_all = m_bcd; e.dp_all = m_dp; e.valid_all = m_valid;
    sb.push_back(e);
  endtask

  function automatic int idx_of(input logic [3:0] dn);
    int r = 0;
    for (int i = 0; i < 4; i++) if (dn[i] == 1'b0) r = i;
    return r;
  endfunction

  // Monitor: every upd pops one expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (upd === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_upd: got upd=1 idx=%0d bcd=%h, expected no update", upd_idx, bcd_out);
        end else begin
          exp_t e;
          logic [3:0] vm;
          e  = sb.pop_front();
          vm = (vmask == 4'hF) ? 4'hF : 4'(1 << e.idx);
          $display("commit idx=%0d bcd=%h dp=%b valid=%b err=%b", upd_idx, bcd_out, dp_out, digit_valid, err);
          check("upd_idx", 32'(upd_idx), 32'(e.idx));
          check("err", 32'(err), 32'(e.err));
          check("bcd_out", 32'(bcd_out), 32'(e.bcd_all));
          check("dp_out", 32'(dp_out), 32'(e.dp_all));
          check("digit_valid", 32'(digit_valid & vm), 32'(e.valid_all & vm));
        end
      end else if (err !== 1'b0) begin
        n_vec++; n_bad++;
        $display("FAIL err_without_upd: got err=%b, expected 0", err);
      end
    end
  end

  vec_t vecs [13];
  logic [5:0] hist;

  initial begin
`ifdef SEG7_READER_TIMEOUT_EN
    vmask = 4'h0;
`endif
    vecs[0]  = '{4'b1110, 7'h3F, 1'b0, 4, 1'b1};
    vecs[1]  = '{4'b1110, 7'h3F, 1'b1, 4, 1'b1};  // dp-only change
    vecs[2]  = '{4'b1101, 7'h00, 1'b1, 4, 1'b1};  // blank
    vecs[3]  = '{4'b1011, 7'h77, 1'b0, 3, 1'b1};  // exactly STABLE_CNT
    vecs[4]  = '{4'b0111, 7'h7C, 1'b0, 2, 1'b0};  // too short
    vecs[5]  = '{4'b0111, 7'h39, 1'b0, 4, 1'b1};
    vecs[6]  = '{4'b1110, 7'h5E, 1'b0, 4, 1'b1};
    vecs[7]  = '{4'b1101, 7'h79, 1'b1, 4, 1'b1};
    vecs[8]  = '{4'b1011, 7'h71, 1'b0, 4, 1'b1};
    vecs[9]  = '{4'b0111, 7'h08, 1'b0, 4, 1'b1};  // unknown glyph
    vecs[10] = '{4'b0000, 7'h6F, 1'b0, 4, 1'b0};  // all selected
    vecs[11] = '{4'b1111, 7'h6F, 1'b0, 4, 1'b0};  // none selected
    vecs[12] = '{4'b0111, 7'h07, 1'b0, 4, 1'b1};

    // Reset and idle.
    rst = 1'b1; idle();
    tick(2);
    check("reset_state", {3'b0, bcd_out, dp_out, digit_valid, upd, upd_idx, err}, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(100);
    check("idle_state", {3'b0, bcd_out, dp_out, digit_valid, upd, upd_idx, err}, 32'h0);

    // Latency: upd only after the 5th edge.
    drive(4'b1110, 7'h5B, 1'b1);
    expect_commit(0, 7'h5B, 1'b1);
    for (int c = 0; c < 6; c++) begin
      tick(1);
      hist[c] = upd;
    end
    check("latency_upd_pattern", 32'(hist), 32'b010000);
    idle(); tick(6);
    check("digit0_two", 32'(bcd_out[3:0]), 32'h2);

    // Scan four digits.
    for (int d = 0; d < 4; d++) begin
      logic [6:0] sc [4] = '{7'h06, 7'h4F, 7'h66, 7'h7D};
      drive(~(4'b0001 << d), sc[d], 1'b0);
      expect_commit(d, sc[d], 1'b0);
      tick(4);
    end
    idle(); tick(8);
    check("scan_bcd", 32'(bcd_out), 32'h6431);
    check("scan_valid", 32'(digit_valid), 32'hF);

    // Two digits selected, then a short glitch: no commits.
    drive(4'b1100, 7'h7F, 1'b0); tick(10);
    drive(4'b1110, 7'h7F, 1'b0); tick(2);
    idle(); tick(8);
    check("no_commit_bcd", 32'(bcd_out), 32'h6431);

    // Unknown pattern on digit 2.
    drive(4'b1011, 7'h41, 1'b0);
    expect_commit(2, 7'h41, 1'b0);
    tick(5);
    idle(); tick(6);
    check("err_nibble", 32'(bcd_out[11:8]), 32'hF);
    check("err_valid2", 32'(digit_valid[2]), 32'h0);

    // Table of vectors, then every glyph.
    for (int k = 0; k < 13; k++) begin
      drive(vecs[k].dn, vecs[k].seg, vecs[k].dpv);
      if (vecs[k].commits) expect_commit(idx_of(vecs[k].dn), vecs[k].seg, vecs[k].dpv);
      $display("vec %0d dig_n=%b seg=%h dp=%b hold=%0d", k, vecs[k].dn, vecs[k].seg, vecs[k].dpv, vecs[k].hold);
      tick(vecs[k].hold);
    end
    for (int v = 0; v < 16; v++) begin
      drive(~(4'b0001 << (v % 4)), glyph_tab[v], v[0]);
      expect_commit(v % 4, glyph_tab[v], v[0]);
      $display("glyph %0d seg=%h", v, glyph_tab[v]);
      tick(4);
    end
    idle(); tick(8);
    check("glyph_final_bcd", 32'(bcd_out), 32'hFEDC);

    // Reset in the middle of a run.
    drive(4'b1101, 7'h6D, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    check("midrun_reset_bcd", 32'(bcd_out), 32'h0);
    expect_commit(1, 7'h6D, 1'b0);
    for (int c = 0; c < 6; c++) begin
      tick(1);
      hist[c] = upd;
    end
    check("post_reset_latency", 32'(hist), 32'b010000);
    idle(); tick(6);

`ifdef SEG7_READER_TIMEOUT_EN
    // Refresh timeout on digit 1.
    drive(4'b1101, 7'h06, 1'b0);
    expect_commit(1, 7'h06, 1'b0);
    tick(5);
    idle();
    tick(49);
    check("timeout_before", 32'(digit_valid[1]), 32'h1);
    tick(1);
    check("timeout_after", 32'(digit_valid[1]), 32'h0);
    check("timeout_bcd", 32'(bcd_out[7:4]), 32'h1);
    tick(4);
`endif

    // Every expected commit must have been observed.
    for (int w = 0; w < 50 && sb.size() != 0; w++) tick(1);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_cc_reader.md
SEG7_CC_READER -- requirements
Module: seg7_cc_reader

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digit positions, range 1..8.
REQ-002 Parameter STABLE_CNT, default 3: consecutive identical synchronized samples required before a commit, range 1..255.
REQ-003 Parameter TIMEOUT_CYC, default 1000000: refresh timeout in clocks (20 ms at 50 MHz); used only with SEG7_READER_TIMEOUT_EN.
REQ-004 Port clk50MHz  input  1: sole clock, rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port Segments  input  7: common-cathode segment anodes, active-high; bit0=a through bit6=g.
REQ-007 Port dp  input  1: decimal-point anode, active-high.
REQ-008 Port dig_n  input  DIGITS: digit cathode selects, active-low; bit i low selects digit i.
REQ-009 Port bcd_out  output  4*DIGITS: decoded value per digit; digit i occupies bits [4i+3:4i].
REQ-010 Port dp_out  output  DIGITS: captured decimal point per digit.
REQ-011 Port digit_valid  output  DIGITS: digit i holds a recognised hex pattern.
REQ-012 Port upd  output  1: one-cycle strobe, asserted in the cycle a commit changes the outputs.
REQ-013 Port upd_idx  output  3: index of the committed digit; meaningful while upd is high.
REQ-014 Port err  output  1: one-cycle strobe, committed pattern is neither a hex glyph nor blank.

Function
REQ-015 Segments, dp and dig_n shall pass through a two-flop synchronizer before any other use.
REQ-016 A sample is qualified only when exactly one dig_n bit is low; zero or several low bits clear the run counter and produce no commit.
REQ-017 The run counter shall increment while {index, Segments, dp} equal the previous cycle's value, reset to 1 on any change, and saturate at STABLE_CNT.
REQ-018 A commit shall occur once per stable run, in the cycle the counter first reaches STABLE_CNT; no re-commit until the run breaks.
REQ-019 Latency from an input change to upd shall be 2 + STABLE_CNT clocks.
REQ-020 Decode (gfedcba hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-021 Recognised pattern: bcd_out digit = value, digit_valid=1, dp_out=dp, upd=1, err=0.
REQ-022 Blank pattern (00): bcd_out digit = 0, digit_valid=0, dp_out=dp, upd=1, err=0.
REQ-023 Any other pattern: bcd_out digit = F, digit_valid=0, dp_out=dp, upd=1, err=1.
REQ-024 Only the committed digit's fields shall change; all other digits hold.
REQ-025 upd and err shall be registered and deasserted in every cycle without a commit.

Reset
REQ-026 While rst is high: bcd_out=0, dp_out=0, digit_valid=0, upd=0, upd_idx=0, err=0, synchronizer flops=all-inactive (dig_n all ones), run counter=0, timeout counters=0.
REQ-027 Reset asserted mid-run discards the run; after release, a full 2 + STABLE_CNT clocks are needed before the next commit.

Configuration
REQ-028 With SEG7_READER_TIMEOUT_EN defined: a per-digit counter shall clear on each commit to that digit and otherwise increment; on reaching TIMEOUT_CYC, digit_valid[i] shall clear with no upd; a commit in the same cycle wins.
REQ-029 Without SEG7_READER_TIMEOUT_EN: no timeout counters shall exist, and digit_valid changes only on commit or reset.

Structure
REQ-030 Package seg7_reader_pkg shall hold the 16-entry glyph table, the SEG_BLANK constant and the width constants.
REQ-031 Sub-module seg7_pattern_decode (combinational: pattern -> hit, blank, value) shall be instantiated once.

Verification
REQ-032 rst high 2 clocks, then all inputs idle for 100 clocks -> all outputs 0, no upd.
REQ-033 dig_n=1110, Segments=5B, dp=1 held 5 clocks (STABLE_CNT=3) -> upd in clock 5 only, upd_idx=0, bcd_out[3:0]=2, dp_out[0]=1, digit_valid[0]=1.
REQ-034 Scan digits 0..3 with 06,4F,66,7D, each for 4 clocks -> bcd_out=16'h6431, digit_valid=1111, four upd pulses.
REQ-035 dig_n=1100 with Segments=7F for 10 clocks -> no upd; a 2-clock glitch pattern -> no upd.
REQ-036 Segments=41 on digit 2 -> err and upd once, bcd_out[11:8]=F, digit_valid[2]=0.
REQ-037 With the macro defined and TIMEOUT_CYC=50: commit digit 1, then idle 50 clocks -> digit_valid[1]=0, bcd_out unchanged, no upd.
